// File: rtl/counter_async_pkg.sv
// Shared constants and helpers for the counter_async timebase.
package counter_async_pkg;

  localparam int unsigned COUNTER_ASYNC_DEFAULT_WIDTH = 4;
  localparam int unsigned COUNTER_ASYNC_RESET_VALUE   = 0;

  // All-ones value of a 'width'-bit counter, i.e. 2**width-1, without 64-bit math.
  function automatic int unsigned counter_async_default_max(input int unsigned width);
    return 32'hFFFF_FFFF >> (32 - width);
  endfunction

endpackage

// File: rtl/counter_async.sv
// Free-running binary up-counter with synchronous active-high reset and a
// configurable terminal value. Fully synchronous to clk despite the name.
// Optional feature macro: COUNTER_ASYNC_SATURATE_EN -- hold at MAX_COUNT
// instead of wrapping to zero.
module counter_async
  import counter_async_pkg::*;
#(
  parameter int unsigned WIDTH     = COUNTER_ASYNC_DEFAULT_WIDTH,
  parameter int unsigned MAX_COUNT = counter_async_default_max(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] count,
  output logic             terminal_count
);

  localparam logic [WIDTH-1:0] MAX_VAL   = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] RESET_VAL = WIDTH'(COUNTER_ASYNC_RESET_VALUE);

  // Elaboration-time parameter legality checks
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("counter_async: WIDTH=%0d outside 1..32", WIDTH);
  end
  if (MAX_COUNT == 0 || MAX_COUNT > counter_async_default_max(WIDTH)) begin : g_bad_max
    $error("counter_async: MAX_COUNT=%0d outside 1..2**WIDTH-1", MAX_COUNT);
  end

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next-state decode: increment, and wrap or saturate at the terminal value
  always_comb begin
    count_d = count_q + WIDTH'(1);
    if (count_q == MAX_VAL) begin
`ifdef COUNTER_ASYNC_SATURATE_EN
      count_d = MAX_VAL;
`else
      count_d = RESET_VAL;
`endif
    end
  end

  // Count register with synchronous reset taking priority over counting
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= RESET_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign count          = count_q;
  assign terminal_count = (count_q == MAX_VAL);

endmodule

// File: tb/tb_counter_async.sv
// Self-checking bench for counter_async: a default-parameter instance driven
// from a vector table, and a MAX_COUNT=9 instance driven by a hand sequence.
module tb_counter_async;

  logic       clk;
  logic       rst_a;
  logic       rst_b;
  logic [3:0] count_a;
  logic [3:0] count_b;
  logic       tc_a;
  logic       tc_b;

  int checks   = 0;
  int failures = 0;

  counter_async dut_def (
    .clk            (clk),
    .reset          (rst_a),
    .count          (count_a),
    .terminal_count (tc_a)
  );

  counter_async #(
    .WIDTH     (4),
    .MAX_COUNT (9)
  ) dut_m9 (
    .clk            (clk),
    .reset          (rst_b),
    .count          (count_b),
    .terminal_count (tc_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic rst;
    int   exp_cnt;
    logic exp_tc;
  } vec_t;

  vec_t vecs[$];

`ifdef COUNTER_ASYNC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input int c, input logic t);
    vec_t v;
    v.rst     = r;
    v.exp_cnt = c;
    v.exp_tc  = t;
    vecs.push_back(v);
  endtask

  // Advance one rising edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int e;
    rst_a = 1'b1;
    rst_b = 1'b1;

    // Power-up reset (2 edges)
    add(1'b1, 0, 1'b0);
    add(1'b1, 0, 1'b0);
    // Release: 1..6
    for (int i = 1; i <= 6; i++) add(1'b0, i, 1'b0);
    // Mid-run reset at 6, then 1..4
    add(1'b1, 0, 1'b0);
    for (int i = 1; i <= 4; i++) add(1'b0, i, 1'b0);
    // Reset, then 20 edges across the terminal value
    add(1'b1, 0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      if (SAT) e = (i > 15) ? 15 : i;
      else     e = i % 16;
      add(1'b0, e, (e == 15));
    end
    // Reset clears from terminal/wrapped state
    add(1'b1, 0, 1'b0);

    for (int k = 0; k < vecs.size(); k++) begin
      rst_a = vecs[k].rst;
      step();
      chk($sformatf("vec%0d_count", k), 32'(count_a), 32'(vecs[k].exp_cnt));
      chk($sformatf("vec%0d_tc", k), 32'(tc_a), 32'(vecs[k].exp_tc));
    end

    // Reset must not be combinationally visible on count
    rst_a = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("pre_reset_count", 32'(count_a), 32'd3);
    rst_a = 1'b1;
    #3;
    chk("reset_not_comb", 32'(count_a), 32'd3);
    step();
    chk("reset_one_edge", 32'(count_a), 32'd0);
    chk("reset_tc_low", 32'(tc_a), 32'd0);
    rst_a = 1'b0;
    step();
    chk("resume_from_zero", 32'(count_a), 32'd1);

    // MAX_COUNT=9 instance: held in reset so far
    chk("m9_reset_count", 32'(count_b), 32'd0);
    chk("m9_reset_tc", 32'(tc_b), 32'd0);
    rst_b = 1'b0;
    for (int i = 1; i <= 22; i++) begin
      step();
      if (SAT) e = (i > 9) ? 9 : i;
      else     e = i % 10;
      chk($sformatf("m9_edge%0d_count", i), 32'(count_b), 32'(e));
      chk($sformatf("m9_edge%0d_tc", i), 32'(tc_b), 32'(e == 9));
    end
    rst_b = 1'b1;
    step();
    chk("m9_final_reset", 32'(count_b), 32'd0);
    chk("m9_final_tc", 32'(tc_b), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/counter_async.md
# counter_async

Free-running binary up-counter with synchronous active-high reset and a configurable terminal value. It is a general-purpose timebase and event-sequencing primitive for datapath and control blocks. The name is historical: the block is fully synchronous to `clk`.

## Interface

Parameters:

- `WIDTH`, default 4: counter width in bits; legal range 1–32.
- `MAX_COUNT`, default `2**WIDTH-1`: terminal value. Must satisfy `0 < MAX_COUNT <= 2**WIDTH-1`.

Ports (one clock; reset is synchronous and active-high):

- `clk`  input  1  rising-edge clock; all state changes occur on this edge.
- `reset`  input  1  synchronous active-high reset, sampled on the rising edge of `clk`.
- `count`  output  `WIDTH`  current count value, registered.
- `terminal_count`  output  1  high while `count == MAX_COUNT`; combinational decode of the `count` register. May be left unconnected.

## Operation

- **Reset:**
  - On a rising edge with `reset == 1`, `count` loads 0.
  - Reset has priority over counting.
  - While `reset` is held high, `count` stays 0 on every edge.
- **Counting:**
  - On a rising edge with `reset == 0`, `count` increments by 1.
  - The increment uses unsigned `WIDTH`-bit arithmetic.
- **Wrap:**
  - When `count == MAX_COUNT` and `reset == 0`, the next edge loads 0.
  - For the default `MAX_COUNT`, this is the natural modulo-`2**WIDTH` rollover: 15 -> 0 at `WIDTH=4`.
  - Values above `MAX_COUNT` are unreachable.
- **Mid-operation reset:**
  - An assertion of `reset` at any count value clears `count` to 0 on the next rising edge.
  - There is no partial or held state.
  - After release, counting resumes from 0. The first edge with `reset == 0` produces 1.
- **`terminal_count`:** equals `(count == MAX_COUNT)`. It is 0 during reset because `count` is 0 and `MAX_COUNT > 0`.
- **Initial state:** before the first reset edge, outputs are undefined (X in simulation). No initial value is relied upon.

## Timing

- Latency from a `reset` change to `count` is one rising edge. `reset` is never combinationally visible on `count`.
- `count` changes only immediately after a rising edge of `clk`.
- `terminal_count` is valid in the same cycle as `count`. It is purely combinational from the register, with no extra pipeline stage.
- Synchronous assertion or deassertion of `reset` must meet setup/hold relative to `clk`. Stimulus applies `reset` away from the active edge.
- Throughput is one increment per clock. There is no enable input and no stall.

## Configuration

- **`COUNTER_ASYNC_SATURATE_EN` defined:**
  - At `count == MAX_COUNT` with `reset == 0`, `count` holds at `MAX_COUNT` instead of wrapping.
  - `terminal_count` stays high until reset.
  - Reset still clears to 0.
- **Macro not defined (default):** wrap behaviour as described in Operation.

## Structure

- Shared package `counter_async_pkg` holds:
  - `COUNTER_ASYNC_DEFAULT_WIDTH` (4);
  - `COUNTER_ASYNC_RESET_VALUE` (0);
  - a helper function computing the default `MAX_COUNT` from `WIDTH`.
- Implementation consists of:
  - one registered process for `count`;
  - a combinational next-state expression (wrap or saturate per the macro);
  - a continuous assignment for `terminal_count`.
- Elaboration-time parameter checks (`MAX_COUNT` range, `WIDTH` range) belong in the module.
- No sub-module is warranted; the logic is a single register plus its next-state decode.

## Test plan

All scenarios use a 10 ns clock period.

- **Power-up reset:** hold `reset=1` for 2 edges -> `count=0`, `terminal_count=0`.
- **Release:** deassert `reset` and run 6 edges -> `count` steps 1, 2, 3, 4, 5, 6.
- **Mid-run reset:**
  - At `count=6`, assert `reset` for 1 edge -> `count=0`.
  - Deassert and run 4 edges -> `count` steps 1, 2, 3, 4.
- **Wrap at defaults:**
  - Run 15 edges from reset -> `count=15` with `terminal_count=1`.
  - Next edge -> `count=0`, `terminal_count=0`.
- **`MAX_COUNT=9`, `WIDTH=4`:** sequence 0..9 then 0. `terminal_count=1` only at 9; values 10–15 never appear.
- **With `COUNTER_ASYNC_SATURATE_EN`:**
  - Run 20 edges from reset -> `count` holds at 15 and `terminal_count` stays 1.
  - Assert `reset` -> `count=0`.
